// File: rtl/min_sec_counter_pkg.sv
// min_sec_counter_pkg: shared state encoding, digit limits and widths for the minutes:seconds counter.
package min_sec_counter_pkg;
    typedef enum logic {STOP, RUN} state_t;
    localparam int TENS_W    = 3;
    localparam int UNITS_W   = 4;
    localparam int TENS_MAX  = 5;
    localparam int UNITS_MAX = 9;
endpackage

// File: rtl/min_sec_counter_if.sv
// min_sec_counter_if: button inputs and digit/status outputs of the counter core.
interface min_sec_counter_if;
    import min_sec_counter_pkg::*;
    logic               nSTART;
    logic               nCLEAR;
    logic [TENS_W-1:0]  secup;
    logic [UNITS_W-1:0] seclow;
    logic [TENS_W-1:0]  minup;
    logic [UNITS_W-1:0] minlow;
    logic               running;
    logic               wrap;
    modport master (output nSTART, nCLEAR, input secup, seclow, minup, minlow, running, wrap);
    modport slave  (input nSTART, nCLEAR, output secup, seclow, minup, minlow, running, wrap);
endinterface

// File: rtl/min_sec_counter_btn_edge.sv
// btn_edge: 2-flop synchronizer plus one-cycle pulse on each high-to-low button transition.
module btn_edge (
    input  logic CLK,
    input  logic nRST,
    input  logic nbtn,
    output logic press
);
    logic [2:0] sr;
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) sr <= '1;
        else sr <= {sr[1:0], nbtn};
    assign press = sr[2] & ~sr[1];
endmodule

// File: rtl/min_sec_counter.sv
// min_sec_counter: 1 Hz prescaler and BCD 00:00..59:59 counter with run/stop and clear buttons.
module min_sec_counter
    import min_sec_counter_pkg::*;
#(
    parameter int DIV_MAX = 50_000_000
) (
    input logic              CLK,
    input logic              nRST,
    min_sec_counter_if.slave io
);
    localparam int PW = $clog2(DIV_MAX);
    localparam logic [PW-1:0]      P_ONE  = PW'(1);
    localparam logic [PW-1:0]      P_LAST = PW'(DIV_MAX - 1);
    localparam logic [TENS_W-1:0]  T_ONE  = TENS_W'(1);
    localparam logic [TENS_W-1:0]  T_MAX  = TENS_W'(TENS_MAX);
    localparam logic [UNITS_W-1:0] U_ONE  = UNITS_W'(1);
    localparam logic [UNITS_W-1:0] U_MAX  = UNITS_W'(UNITS_MAX);
    state_t             state, state_d;
    logic [PW-1:0]      presc, presc_d;
    logic [UNITS_W-1:0] sl, ml, sl_d, ml_d;
    logic [TENS_W-1:0]  su, mu, su_d, mu_d;
    logic               start_p, clear_p, tick, c1, c2, c3, c4, wrap_d;
    btn_edge u_start (.CLK(CLK), .nRST(nRST), .nbtn(io.nSTART), .press(start_p));
    btn_edge u_clear (.CLK(CLK), .nRST(nRST), .nbtn(io.nCLEAR), .press(clear_p));
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            state      <= STOP;
            io.running <= 1'b0;
            io.wrap    <= 1'b0;
            presc      <= '0;
            sl         <= '0;
            su         <= '0;
            ml         <= '0;
            mu         <= '0;
        end else begin
            state      <= state_d;
            io.running <= state_d == RUN;
            io.wrap    <= wrap_d;
            presc      <= presc_d;
            sl         <= sl_d;
            su         <= su_d;
            ml         <= ml_d;
            mu         <= mu_d;
        end
    // Carries ripple through all four digits in one cycle; a stop press still lets the tick land.
    always_comb begin
        tick    = state == RUN && presc == P_LAST;
        presc_d = state == RUN ? (tick ? '0 : presc + P_ONE) : presc;
        c1      = tick && sl == U_MAX;
        c2      = c1 && su == T_MAX;
        c3      = c2 && ml == U_MAX;
        c4      = c3 && mu == T_MAX;
        sl_d    = tick ? (c1 ? '0 : sl + U_ONE) : sl;
        su_d    = c1 ? (c2 ? '0 : su + T_ONE) : su;
        ml_d    = c2 ? (c3 ? '0 : ml + U_ONE) : ml;
        mu_d    = c3 ? (c4 ? '0 : mu + T_ONE) : mu;
        wrap_d  = c4;
        state_d = start_p ? (state == RUN ? STOP : RUN) : state;
        if (clear_p) begin
            presc_d = '0;
            sl_d    = '0;
            su_d    = '0;
            ml_d    = '0;
            mu_d    = '0;
            wrap_d  = 1'b0;
            state_d = STOP;
        end
    end
    assign io.secup  = su;
    assign io.seclow = sl;
    assign io.minup  = mu;
    assign io.minlow = ml;
endmodule

// File: tb/tb_min_sec_counter.sv
// tb_min_sec_counter: directed vector table, corner sequences and random button traffic against a seconds-count model.
module tb_min_sec_counter;
    import min_sec_counter_pkg::*;
    localparam int D = 4;
    typedef struct {
        bit st;
        bit cl;
        int cyc;
        int secs;
        bit run;
        bit wr;
    } vec_t;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic st_drv = 1'b1;
    logic cl_drv = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    int m_secs, m_phase;
    bit m_run, m_wrap;
    bit [2:0] hs, hc;
    vec_t tbl[14];
    min_sec_counter_if io();
    assign io.nSTART = st_drv;
    assign io.nCLEAR = cl_drv;
    min_sec_counter #(.DIV_MAX(D)) dut (.CLK(CLK), .nRST(nRST), .io(io));
    always #5 CLK = ~CLK;

    function automatic logic [15:0] exp_vec(int secs, bit run, bit wr);
        return {3'(secs / 600), 4'((secs / 60) % 10), 3'((secs % 60) / 10), 4'(secs % 10), run, wr};
    endfunction

    function automatic logic [15:0] act();
        return {io.minup, io.minlow, io.secup, io.seclow, io.running, io.wrap};
    endfunction

    task automatic check(string name, logic [15:0] a, logic [15:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, a, e);
        end
    endtask

    task automatic model_reset();
        m_secs = 0;
        m_phase = 0;
        m_run = 0;
        m_wrap = 0;
        hs = '1;
        hc = '1;
    endtask

    // A button level first sampled low at edge k acts at edge k+2.
    task automatic model_edge();
        bit sp, cp, tk;
        sp = !hs[1] && hs[2];
        cp = !hc[1] && hc[2];
        hs = {hs[1:0], st_drv};
        hc = {hc[1:0], cl_drv};
        if (cp) begin
            m_secs = 0;
            m_phase = 0;
            m_run = 0;
            m_wrap = 0;
        end else begin
            tk = m_run && m_phase == D - 1;
            if (m_run) m_phase = (m_phase + 1) % D;
            m_wrap = tk && m_secs == 3599;
            if (tk) m_secs = (m_secs + 1) % 3600;
            if (sp) m_run = !m_run;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check("model", act(), exp_vec(m_secs, m_run, m_wrap));
        check("digit_range", 16'({io.minup <= 5, io.minlow <= 9, io.secup <= 5, io.seclow <= 9}), 16'hF);
    endtask

    task automatic press(bit s, bit c);
        st_drv = !s;
        cl_drv = !c;
        step();
        st_drv = 1'b1;
        cl_drv = 1'b1;
    endtask

    initial begin
        int rem;
        model_reset();
        repeat (3) @(negedge CLK);
        check("reset_state", act(), 16'h0);
        nRST = 1'b1;
        repeat (20) step();
        check("idle", act(), exp_vec(0, 0, 0));
        tbl[0]  = '{1, 0, 243, 60, 1, 0};
        tbl[1]  = '{0, 0, 14152, 3598, 1, 0};
        tbl[2]  = '{0, 0, 4, 3599, 1, 0};
        tbl[3]  = '{0, 0, 4, 0, 1, 1};
        tbl[4]  = '{0, 0, 1, 0, 1, 0};
        tbl[5]  = '{0, 0, 2, 0, 1, 0};
        tbl[6]  = '{1, 0, 3, 1, 0, 0};
        tbl[7]  = '{0, 0, 10, 1, 0, 0};
        tbl[8]  = '{1, 0, 3, 1, 1, 0};
        tbl[9]  = '{0, 0, 1, 1, 1, 0};
        tbl[10] = '{0, 0, 1, 2, 1, 0};
        tbl[11] = '{0, 0, 3008, 754, 1, 0};
        tbl[12] = '{1, 1, 3, 0, 0, 0};
        tbl[13] = '{0, 0, 5, 0, 0, 0};
        for (int i = 0; i < 14; i++) begin
            rem = tbl[i].cyc;
            if (tbl[i].st || tbl[i].cl) begin
                press(tbl[i].st, tbl[i].cl);
                rem--;
            end
            repeat (rem) step();
            check($sformatf("vec%0d", i), act(), exp_vec(tbl[i].secs, tbl[i].run, tbl[i].wr));
        end
        press(1, 0);
        repeat (2 + 307 * D) step();
        check("pre_reset", act(), exp_vec(307, 1, 0));
        #1 nRST = 1'b0;
        model_reset();
        #1 check("async_reset", act(), 16'h0);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (8) step();
        check("after_reset", act(), exp_vec(0, 0, 0));
        repeat (3000) begin
            st_drv = $urandom_range(0, 15) != 0;
            cl_drv = $urandom_range(0, 79) != 0;
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
